// File: rtl/mips_pkg.sv
// mips_pkg: register-file widths, zero-register index and index type shared by reg_file_2r1w and reg_scoreboard
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: DEPTH busy bits, set by issue (set wins) and cleared by writeback, with two lookups; ports clk/reset, set_en/set_addr, clr_en/clr_addr, addr_a/addr_b -> busy_a/busy_b
module reg_scoreboard
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              busy_a,
  output logic              busy_b
);
  logic [DEPTH-1:0] busy, set_m, clr_m;
  always_comb begin
    set_m = (set_en && set_addr != REG_ZERO) ? DEPTH'(1) << set_addr : '0;
    clr_m = clr_en ? DEPTH'(1) << clr_addr : '0;
    busy_a = busy[addr_a];
    busy_b = busy[addr_b];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) busy <= '0;
    else busy <= (busy & ~clr_m) | set_m;
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: MIPS 2-read/1-write register file with busy scoreboard and stall; ports clk/reset, rd_req/rd_addr_a/rd_addr_b -> rd_stall/rd_valid/rd_data_a/rd_data_b, iss_en/iss_addr, wb_en/wb_addr/wb_data; REGFILE_BYPASS_EN enables writeback write-through
module reg_file_2r1w
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_stall,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] op_a, op_b;
  logic busy_a, busy_b, byp_a, byp_b, haz_a, haz_b, acc;
  reg_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (iss_en),
    .set_addr (iss_addr),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .addr_a   (rd_addr_a),
    .addr_b   (rd_addr_b),
    .busy_a   (busy_a),
    .busy_b   (busy_b)
  );
`ifdef REGFILE_BYPASS_EN
  assign byp_a = wb_en && wb_addr == rd_addr_a && rd_addr_a != REG_ZERO;
  assign byp_b = wb_en && wb_addr == rd_addr_b && rd_addr_b != REG_ZERO;
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif
  always_comb begin
    haz_a = busy_a && rd_addr_a != REG_ZERO && !byp_a;
    haz_b = busy_b && rd_addr_b != REG_ZERO && !byp_b;
    rd_stall = rd_req && (haz_a || haz_b);
    acc = rd_req && !rd_stall;
    op_a = byp_a ? wb_data : mem[rd_addr_a];
    op_b = byp_b ? wb_data : mem[rd_addr_b];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_valid <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      if (wb_en && wb_addr != REG_ZERO) mem[wb_addr] <= wb_data;
      rd_valid <= acc;
      if (acc) begin
        rd_data_a <= op_a;
        rd_data_b <= op_b;
      end
    end
endmodule
